// File: rtl/sample_mem_sequencer.sv
// Sequences the shared single-port sample RAM between ACQUIRE (ADC -> RAM)
// and SEND (RAM -> UART, two bytes per sample, MSB first).
module sample_mem_sequencer #(
  parameter int AW        = 10,
  parameter int N_SAMPLES = 1000
) (
  input  logic          CLOCK_50,
  input  logic          KEY,
  input  logic          clear,
  input  logic          acquire_signal,
  input  logic          send_signal,
  input  logic          adc_valid,
  input  logic [15:0]   adc_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic          tx_start,
  output logic [7:0]    tx_byte,
  input  logic          tx_busy,
  output logic          busy,
  output logic          acq_done,
  output logic          send_done,
  output logic          data_valid,
  output logic          cmd_err
);

  typedef enum logic [3:0] {
    IDLE, ACQ, RD, RDWAIT, TXH, TXH_G, TXL, TXL_G, DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N_SAMPLES - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] addr_nxt;
  logic          we_nxt;
  logic [15:0]   wdata_nxt;
  logic [15:0]   data, data_nxt;
  logic          dv_nxt, err_nxt;
  logic          done_acq, done_acq_nxt;
  logic          acq_q, send_q;
  logic          acq_rise, send_rise;

  assign acq_rise  = acquire_signal & ~acq_q;
  assign send_rise = send_signal & ~send_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    addr_nxt     = mem_addr;
    we_nxt       = 1'b0;
    wdata_nxt    = mem_wdata;
    data_nxt     = data;
    dv_nxt       = data_valid;
    err_nxt      = cmd_err;
    done_acq_nxt = done_acq;
    tx_start     = 1'b0;
    tx_byte      = 8'h00;

    unique case (state)
      IDLE: begin
        if (acq_rise) begin
          state_nxt    = ACQ;
          ptr_nxt      = '0;
          dv_nxt       = 1'b0;
          done_acq_nxt = 1'b1;
          if (send_rise) err_nxt = 1'b1;
        end else if (send_rise) begin
          if (data_valid) begin
            state_nxt = RD;
            ptr_nxt   = '0;
            addr_nxt  = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACQ: begin
        if (adc_valid) begin
          we_nxt    = 1'b1;
          addr_nxt  = ptr;
          wdata_nxt = adc_data;
          if (ptr == LAST) begin
            state_nxt    = DONE;
            dv_nxt       = 1'b1;
            done_acq_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + AW'(1);
          end
        end
      end
      RD:     state_nxt = RDWAIT;
      RDWAIT: begin
        data_nxt  = mem_rdata;
        state_nxt = TXH;
      end
      TXH: begin
        tx_byte = data[15:8];
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = TXH_G;
        end
      end
      // Guard cycle: the transmitter may need a cycle to raise tx_busy.
      TXH_G:  state_nxt = TXL;
      TXL: begin
        tx_byte = data[7:0];
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = TXL_G;
        end
      end
      TXL_G: begin
        if (ptr == LAST) begin
          state_nxt    = DONE;
          done_acq_nxt = 1'b0;
        end else begin
          ptr_nxt   = ptr + AW'(1);
          addr_nxt  = ptr + AW'(1);
          state_nxt = RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && (acq_rise || send_rise)) err_nxt = 1'b1;

    if (clear) begin
      state_nxt    = IDLE;
      ptr_nxt      = '0;
      addr_nxt     = '0;
      we_nxt       = 1'b0;
      wdata_nxt    = '0;
      data_nxt     = '0;
      dv_nxt       = 1'b0;
      err_nxt      = 1'b0;
      done_acq_nxt = 1'b0;
      tx_start     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state      <= IDLE;
      ptr        <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      cmd_err    <= 1'b0;
      done_acq   <= 1'b0;
      acq_q      <= 1'b0;
      send_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      mem_addr   <= addr_nxt;
      mem_we     <= we_nxt;
      mem_wdata  <= wdata_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      cmd_err    <= err_nxt;
      done_acq   <= done_acq_nxt;
      acq_q      <= clear ? 1'b0 : acquire_signal;
      send_q     <= clear ? 1'b0 : send_signal;
    end
  end

  assign busy      = (state != IDLE);
  assign acq_done  = (state == DONE) &  done_acq;
  assign send_done = (state == DONE) & ~done_acq;

endmodule
